// File: rtl/mem_access.sv
// MEM pipeline stage: drives a handshaked data-memory port, stalls the pipeline
// while an access is outstanding and loads the MEM/WB register.
module mem_access #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       ip_ALU_result,
   input  logic [7:0]        ip_Add_result,
   input  logic [31:0]       ip_memory_write_data,
   input  logic [4:0]        ip_dest_reg,
   input  logic              ip_zero,
   input  logic              ip_branch,
   input  logic              ip_MemtoReg,
   input  logic              ip_RegWrite,
   input  logic              ip_read_en,
   input  logic              ip_write_en,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata,
   output logic              op_stall,
   output logic              op_PCSrc,
   output logic [7:0]        op_branch_target,
   output logic [31:0]       op_read_data,
   output logic [31:0]       op_ALU_result,
   output logic [4:0]        op_dest_reg,
   output logic              op_MemtoReg,
   output logic              op_RegWrite,
   output logic [31:0]       op_wb_data,
   output logic              op_bus_error
);

   localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   typedef enum logic {S_IDLE, S_REQ} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic             access;
   logic             ack_req;
   logic             timeout;
   logic             done;
   logic             unused_addr_bits;

   // Byte-offset and high address bits never reach the word-addressed memory.
   assign unused_addr_bits = ^{ip_ALU_result[1:0], ip_ALU_result[31:ADDR_W+2]};

   assign access  = ip_read_en | ip_write_en;
   assign ack_req = (state == S_REQ) & dmem_ack;
   assign timeout = (state == S_REQ) & ~dmem_ack & (wait_cnt == CNT_W'(MAX_WAIT));
   assign done    = ack_req | timeout;

   assign op_stall = ((state == S_IDLE) & access) |
                     ((state == S_REQ) & ~dmem_ack & ~timeout);

   assign op_PCSrc         = ip_branch & ip_zero;
   assign op_branch_target = ip_Add_result;
   assign op_wb_data       = op_MemtoReg ? op_read_data : op_ALU_result;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         S_IDLE: begin
            if (access) begin
               state_nxt    = S_REQ;
               wait_cnt_nxt = '0;
            end
         end
         S_REQ: begin
            if (done) begin
               state_nxt = S_IDLE;
            end else if (wait_cnt != CNT_W'(MAX_WAIT)) begin
               wait_cnt_nxt = wait_cnt + CNT_W'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Request fields are captured once on entry and held for the whole access.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
      end else begin
         dmem_req <= (state_nxt == S_REQ);
         if ((state == S_IDLE) && access) begin
            dmem_we    <= ip_write_en;
            dmem_addr  <= ip_ALU_result[ADDR_W+1:2];
            dmem_wdata <= ip_memory_write_data;
         end
      end
   end

   // MEM/WB register: bubble while stalled, otherwise advance.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_read_data  <= '0;
         op_ALU_result <= '0;
         op_dest_reg   <= '0;
         op_MemtoReg   <= 1'b0;
         op_RegWrite   <= 1'b0;
         op_bus_error  <= 1'b0;
      end else begin
         if (op_stall) begin
            op_MemtoReg <= 1'b0;
            op_RegWrite <= 1'b0;
         end else begin
            op_ALU_result <= ip_ALU_result;
            op_dest_reg   <= ip_dest_reg;
            op_MemtoReg   <= ip_MemtoReg;
            op_RegWrite   <= ip_RegWrite;
            op_read_data  <= (ack_req && !dmem_we) ? dmem_rdata : 32'h0;
         end
         if (timeout) begin
            op_bus_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: ALU pass-through, load, store,
// timeout, asynchronous reset mid-access and branch outputs.
module tb_mem_access;

   logic        clock;
   logic        reset;
   logic [31:0] ip_ALU_result;
   logic [7:0]  ip_Add_result;
   logic [31:0] ip_memory_write_data;
   logic [4:0]  ip_dest_reg;
   logic        ip_zero, ip_branch, ip_MemtoReg, ip_RegWrite, ip_read_en, ip_write_en;
   logic        dmem_req, dmem_we;
   logic [7:0]  dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        op_stall, op_PCSrc;
   logic [7:0]  op_branch_target;
   logic [31:0] op_read_data, op_ALU_result, op_wb_data;
   logic [4:0]  op_dest_reg;
   logic        op_MemtoReg, op_RegWrite, op_bus_error;

   int n_cmp = 0;
   int n_err = 0;

   mem_access #(.ADDR_W(8), .MAX_WAIT(15)) dut (
      .clock                (clock),
      .reset                (reset),
      .ip_ALU_result        (ip_ALU_result),
      .ip_Add_result        (ip_Add_result),
      .ip_memory_write_data (ip_memory_write_data),
      .ip_dest_reg          (ip_dest_reg),
      .ip_zero              (ip_zero),
      .ip_branch            (ip_branch),
      .ip_MemtoReg          (ip_MemtoReg),
      .ip_RegWrite          (ip_RegWrite),
      .ip_read_en           (ip_read_en),
      .ip_write_en          (ip_write_en),
      .dmem_req             (dmem_req),
      .dmem_we              (dmem_we),
      .dmem_addr            (dmem_addr),
      .dmem_wdata           (dmem_wdata),
      .dmem_ack             (dmem_ack),
      .dmem_rdata           (dmem_rdata),
      .op_stall             (op_stall),
      .op_PCSrc             (op_PCSrc),
      .op_branch_target     (op_branch_target),
      .op_read_data         (op_read_data),
      .op_ALU_result        (op_ALU_result),
      .op_dest_reg          (op_dest_reg),
      .op_MemtoReg          (op_MemtoReg),
      .op_RegWrite          (op_RegWrite),
      .op_wb_data           (op_wb_data),
      .op_bus_error         (op_bus_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      ip_ALU_result        = '0;
      ip_Add_result        = '0;
      ip_memory_write_data = '0;
      ip_dest_reg          = '0;
      ip_zero              = 1'b0;
      ip_branch            = 1'b0;
      ip_MemtoReg          = 1'b0;
      ip_RegWrite          = 1'b0;
      ip_read_en           = 1'b0;
      ip_write_en          = 1'b0;
      dmem_ack             = 1'b0;
      dmem_rdata           = '0;
   endtask

   initial begin
      int stall_cnt;
      int req_cycles;
      reset = 1'b0;
      clear_inputs();
      #3;
      check_val("rst_req",      32'(dmem_req), 32'h0);
      check_val("rst_regwrite", 32'(op_RegWrite), 32'h0);
      check_val("rst_buserr",   32'(op_bus_error), 32'h0);
      tick();
      reset = 1'b1;

      // ALU op passes through without stalling
      ip_ALU_result = 32'h5; ip_RegWrite = 1'b1; ip_dest_reg = 5'd3;
      #1 check_val("alu_stall", 32'(op_stall), 32'h0);
      tick();
      check_val("alu_result", op_ALU_result, 32'h5);
      check_val("alu_dest",   32'(op_dest_reg), 32'h3);
      check_val("alu_regwr",  32'(op_RegWrite), 32'h1);
      check_val("alu_wb",     op_wb_data, 32'h5);

      // Load at 0x10, ack in first REQ cycle
      ip_ALU_result = 32'h10; ip_read_en = 1'b1; ip_MemtoReg = 1'b1; ip_dest_reg = 5'd7;
      #1 check_val("ld_stall_idle", 32'(op_stall), 32'h1);
      tick();
      check_val("ld_req",    32'(dmem_req), 32'h1);
      check_val("ld_addr",   32'(dmem_addr), 32'h4);
      check_val("ld_we",     32'(dmem_we), 32'h0);
      check_val("ld_bubble", 32'(op_RegWrite), 32'h0);
      dmem_ack = 1'b1; dmem_rdata = 32'hCAFE;
      #1 check_val("ld_stall_ack", 32'(op_stall), 32'h0);
      tick();
      clear_inputs();
      check_val("ld_req_done", 32'(dmem_req), 32'h0);
      check_val("ld_rdata",    op_read_data, 32'hCAFE);
      check_val("ld_wb",       op_wb_data, 32'hCAFE);
      check_val("ld_m2r",      32'(op_MemtoReg), 32'h1);
      check_val("ld_regwr",    32'(op_RegWrite), 32'h1);
      check_val("ld_dest",     32'(op_dest_reg), 32'h7);

      // Store 0x1234 to 0x20, ack in the fourth REQ cycle
      ip_ALU_result = 32'h20; ip_write_en = 1'b1; ip_memory_write_data = 32'h1234;
      stall_cnt = 0;
      #1 if (op_stall) stall_cnt++;
      tick();
      for (int k = 1; k <= 4; k++) begin
         dmem_ack = (k == 4);
         #1;
         check_val("st_req",   32'(dmem_req), 32'h1);
         check_val("st_we",    32'(dmem_we), 32'h1);
         check_val("st_addr",  32'(dmem_addr), 32'h8);
         check_val("st_wdata", dmem_wdata, 32'h1234);
         check_val("st_bubble", 32'(op_RegWrite), 32'h0);
         if (op_stall) stall_cnt++;
         tick();
      end
      clear_inputs();
      check_val("st_stalls",   32'(stall_cnt), 32'h4);
      check_val("st_req_done", 32'(dmem_req), 32'h0);
      check_val("st_rdata",    op_read_data, 32'h0);
      check_val("st_regwr",    32'(op_RegWrite), 32'h0);

      // dmem_ack outside REQ is ignored
      ip_ALU_result = 32'h77; ip_RegWrite = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hBEEF;
      tick();
      clear_inputs();
      check_val("idle_ack_req",   32'(dmem_req), 32'h0);
      check_val("idle_ack_rdata", op_read_data, 32'h0);
      check_val("idle_ack_alu",   op_ALU_result, 32'h77);

      // Load that is never acknowledged times out
      ip_ALU_result = 32'h40; ip_read_en = 1'b1; ip_MemtoReg = 1'b1; ip_RegWrite = 1'b1;
      ip_dest_reg = 5'd9;
      tick();
      req_cycles = 0;
      stall_cnt  = 0;
      while (dmem_req && req_cycles < 100) begin
         req_cycles++;
         if (op_stall) stall_cnt++;
         tick();
      end
      check_val("to_req_cycles", 32'(req_cycles), 32'd16);
      check_val("to_stalls",     32'(stall_cnt), 32'd15);
      check_val("to_rdata",      op_read_data, 32'h0);
      check_val("to_wb",         op_wb_data, 32'h0);
      check_val("to_regwr",      32'(op_RegWrite), 32'h1);
      check_val("to_buserr",     32'(op_bus_error), 32'h1);
      clear_inputs();
      #1 check_val("to_stall_rel", 32'(op_stall), 32'h0);
      tick();
      tick();
      check_val("to_sticky", 32'(op_bus_error), 32'h1);

      // Asynchronous reset mid-REQ, then a late ack
      ip_ALU_result = 32'h10; ip_read_en = 1'b1; ip_MemtoReg = 1'b1; ip_RegWrite = 1'b1;
      ip_dest_reg = 5'd4; ip_memory_write_data = 32'h55;
      tick();
      tick();
      check_val("rr_req_before", 32'(dmem_req), 32'h1);
      #2 reset = 1'b0;
      #1;
      check_val("rr_req",    32'(dmem_req), 32'h0);
      check_val("rr_addr",   32'(dmem_addr), 32'h0);
      check_val("rr_regwr",  32'(op_RegWrite), 32'h0);
      check_val("rr_alu",    op_ALU_result, 32'h0);
      check_val("rr_dest",   32'(op_dest_reg), 32'h0);
      check_val("rr_buserr", 32'(op_bus_error), 32'h0);
      clear_inputs();
      tick();
      reset = 1'b1;
      dmem_ack = 1'b1; dmem_rdata = 32'hDEAD;
      tick();
      dmem_ack = 1'b0;
      check_val("rr_late_req",   32'(dmem_req), 32'h0);
      check_val("rr_late_rdata", op_read_data, 32'h0);
      check_val("rr_late_regwr", 32'(op_RegWrite), 32'h0);

      // Branch outputs are combinational
      ip_branch = 1'b1; ip_zero = 1'b1; ip_Add_result = 8'h2C;
      #1;
      check_val("br_pcsrc",  32'(op_PCSrc), 32'h1);
      check_val("br_target", 32'(op_branch_target), 32'h2C);
      ip_zero = 1'b0;
      #1 check_val("br_nottaken", 32'(op_PCSrc), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
